// File: rtl/param_wb_loader_pkg.sv
// Shared widths, buffer geometry defaults and FSM state encoding for the
// weight/bias parameter loader.
package param_wb_loader_pkg;

    // Parameter word width; must track the global data width of the WB path.
    localparam int unsigned DEF_BIT_DATA = 8;
    // Partial-sum width used by the downstream compute stages.
    localparam int unsigned DEF_BIT_PSUM = 24;

    localparam int unsigned DEF_P_DEPTH = 16;
    localparam int unsigned DEF_P_ADDR  = 4;
    localparam int unsigned DEF_P_REP_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } state_e;

endpackage

// File: rtl/param_wb_loader_if.sv
// Host/stream bundle of the parameter loader. The loader side uses the slave
// modport, the host and downstream side the master modport.
// Optional stall input is present only when PARAM_WB_LOADER_STALL_EN is defined.
interface param_wb_loader_if #(
    parameter int unsigned BIT_DATA = 8,
    parameter int unsigned P_ADDR   = 4,
    parameter int unsigned P_REP_W  = 8
) ();

    logic                i_Wr_En;
    logic [BIT_DATA-1:0] i_Wr_Data;
    logic                o_Wr_Ready;
    logic                i_Clear;
    logic                i_Start;
    logic [P_REP_W-1:0]  i_Repeat;
`ifdef PARAM_WB_LOADER_STALL_EN
    logic                i_Stall;
`endif
    logic [BIT_DATA-1:0] o_Param_WB;
    logic                o_Valid_WB_Param;
    logic                o_Busy;
    logic                o_Done;
    logic [P_ADDR:0]     o_Count;

    modport slave (
        input  i_Wr_En,
        input  i_Wr_Data,
        input  i_Clear,
        input  i_Start,
        input  i_Repeat,
`ifdef PARAM_WB_LOADER_STALL_EN
        input  i_Stall,
`endif
        output o_Wr_Ready,
        output o_Param_WB,
        output o_Valid_WB_Param,
        output o_Busy,
        output o_Done,
        output o_Count
    );

    modport master (
        output i_Wr_En,
        output i_Wr_Data,
        output i_Clear,
        output i_Start,
        output i_Repeat,
`ifdef PARAM_WB_LOADER_STALL_EN
        output i_Stall,
`endif
        input  o_Wr_Ready,
        input  o_Param_WB,
        input  o_Valid_WB_Param,
        input  o_Busy,
        input  o_Done,
        input  o_Count
    );

endinterface

// File: rtl/param_wb_loader_buf.sv
// Parameter storage: register file with one synchronous write port and one
// combinational read port. Storage is not reset; unwritten entries are never read.
module param_wb_buf #(
    parameter int unsigned BIT_DATA = 8,
    parameter int unsigned P_DEPTH  = 16,
    parameter int unsigned P_ADDR   = 4
) (
    input  logic                clk_i,
    input  logic                wr_en_i,
    input  logic [P_ADDR-1:0]   wr_addr_i,
    input  logic [BIT_DATA-1:0] wr_data_i,
    input  logic [P_ADDR-1:0]   rd_addr_i,
    output logic [BIT_DATA-1:0] rd_data_o
);

    logic [BIT_DATA-1:0] mem_q [P_DEPTH];

    // Synchronous write of one entry.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_wb_loader.sv
// Weight/bias parameter loader: buffers host-written parameters and replays them
// as a contiguous valid stream, (repeat+1) passes, into the WB parameter stage.
// Build option: define PARAM_WB_LOADER_STALL_EN to add the i_Stall stream hold input.
module param_wb_loader
    import param_wb_loader_pkg::*;
#(
    parameter int unsigned BIT_DATA = DEF_BIT_DATA,
    parameter int unsigned P_DEPTH  = DEF_P_DEPTH,
    parameter int unsigned P_ADDR   = DEF_P_ADDR,
    parameter int unsigned P_REP_W  = DEF_P_REP_W
) (
    input  logic             CLK,
    input  logic             RST,
    param_wb_loader_if.slave bus
);

    localparam logic [P_ADDR:0] DepthW = (P_ADDR+1)'(P_DEPTH);
    localparam logic [P_ADDR:0] CntOne = (P_ADDR+1)'(1);

    state_e              state_q, state_d;
    logic [P_ADDR:0]     count_q, count_d;
    logic [P_ADDR:0]     len_q, len_d;
    logic [P_ADDR:0]     eff_count;
    logic [P_ADDR-1:0]   rd_idx_q, rd_idx_d;
    logic [P_REP_W-1:0]  pass_q, pass_d;
    logic [P_REP_W-1:0]  reps_q, reps_d;
    logic [BIT_DATA-1:0] param_q, param_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic [BIT_DATA-1:0] rd_data;
    logic                wr_ready, wr_fire, start_fire;
    logic                stall, advance, last_idx, last_word;

`ifdef PARAM_WB_LOADER_STALL_EN
    assign stall = bus.i_Stall;
`else
    assign stall = 1'b0;
`endif

    assign wr_ready   = (state_q == StIdle) && (count_q < DepthW);
    // A clear without start drops a concurrent write; with start the clear is ignored.
    assign wr_fire    = bus.i_Wr_En && wr_ready && !(bus.i_Clear && !bus.i_Start);
    assign eff_count  = count_q + (P_ADDR+1)'(wr_fire);
    assign start_fire = (state_q == StIdle) && bus.i_Start && (eff_count != '0);
    assign advance    = (state_q == StStream) && !stall;
    assign last_idx   = ({1'b0, rd_idx_q} == (len_q - CntOne));
    assign last_word  = last_idx && (pass_q == reps_q);

    param_wb_buf #(
        .BIT_DATA (BIT_DATA),
        .P_DEPTH  (P_DEPTH),
        .P_ADDR   (P_ADDR)
    ) u_buf (
        .clk_i     (CLK),
        .wr_en_i   (wr_fire),
        .wr_addr_i (count_q[P_ADDR-1:0]),
        .wr_data_i (bus.i_Wr_Data),
        .rd_addr_i (rd_idx_q),
        .rd_data_o (rd_data)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_fire) state_d = StStream;
            StStream: if (advance && last_word) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of buffer count, stream length/repeat latches and read pointers.
    always_comb begin
        count_d  = count_q;
        len_d    = len_q;
        reps_d   = reps_q;
        rd_idx_d = rd_idx_q;
        pass_d   = pass_q;
        if (state_q == StIdle) begin
            if (bus.i_Clear && !bus.i_Start) begin
                count_d = '0;
            end else if (wr_fire) begin
                count_d = eff_count;
            end
            if (start_fire) begin
                len_d    = eff_count;
                reps_d   = bus.i_Repeat;
                rd_idx_d = '0;
                pass_d   = '0;
            end
        end else if (advance) begin
            if (last_idx) begin
                rd_idx_d = '0;
                pass_d   = pass_q + P_REP_W'(1);
            end else begin
                rd_idx_d = rd_idx_q + P_ADDR'(1);
            end
        end
    end

    // Counter and latch registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q  <= '0;
            len_q    <= '0;
            reps_q   <= '0;
            rd_idx_q <= '0;
            pass_q   <= '0;
        end else begin
            count_q  <= count_d;
            len_q    <= len_d;
            reps_q   <= reps_d;
            rd_idx_q <= rd_idx_d;
            pass_q   <= pass_d;
        end
    end

    // FSM output logic: data is zero whenever valid is low.
    always_comb begin
        valid_d = 1'b0;
        param_d = '0;
        done_d  = 1'b0;
        if (advance) begin
            valid_d = 1'b1;
            param_d = rd_data;
        end
        if (state_q == StDone) begin
            done_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            param_q <= '0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            param_q <= param_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_Wr_Ready       = wr_ready;
    assign bus.o_Param_WB       = param_q;
    assign bus.o_Valid_WB_Param = valid_q;
    assign bus.o_Busy           = (state_q == StStream);
    assign bus.o_Done           = done_q;
    assign bus.o_Count          = count_q;

endmodule

// File: tb/tb_param_wb_loader.sv
// Directed/randomized bench for param_wb_loader against a queue-based model.
// Define PARAM_WB_LOADER_STALL_EN to also exercise the stall input.
module tb_param_wb_loader;

    localparam int unsigned BD    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned RW    = 8;

    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;
    int   model_q[$];

    param_wb_loader_if #(.BIT_DATA(BD), .P_ADDR(AW), .P_REP_W(RW)) bus ();

    param_wb_loader #(
        .BIT_DATA (BD),
        .P_DEPTH  (DEPTH),
        .P_ADDR   (AW),
        .P_REP_W  (RW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_Wr_En   = 1'b0;
        bus.i_Wr_Data = '0;
        bus.i_Clear   = 1'b0;
        bus.i_Start   = 1'b0;
`ifdef PARAM_WB_LOADER_STALL_EN
        bus.i_Stall   = 1'b0;
`endif
    endtask

    // One write attempt (optionally with clear) in IDLE.
    task automatic wr(input int data, input bit clr);
        bit exp_ready;
        exp_ready     = (model_q.size() < DEPTH);
        bus.i_Wr_En   = 1'b1;
        bus.i_Wr_Data = data[7:0];
        bus.i_Clear   = clr;
        #1;
        chk("wr_ready", int'(bus.o_Wr_Ready), int'(exp_ready));
        tick();
        idle_inputs();
        if (clr) model_q.delete();
        else if (exp_ready) model_q.push_back(data & 255);
        chk("count_after_wr", int'(bus.o_Count), model_q.size());
    endtask

    task automatic clear();
        bus.i_Clear = 1'b1;
        tick();
        idle_inputs();
        model_q.delete();
        chk("count_after_clear", int'(bus.o_Count), 0);
    endtask

    // Start edge, optionally with a concurrent write and/or clear.
    task automatic start(input int reps, input bit with_wr, input int wdata, input bit with_clr);
        bus.i_Start   = 1'b1;
        bus.i_Repeat  = reps[RW-1:0];
        bus.i_Wr_En   = with_wr;
        bus.i_Wr_Data = wdata[7:0];
        bus.i_Clear   = with_clr;
        tick();
        if (with_wr && model_q.size() < DEPTH) model_q.push_back(wdata & 255);
        idle_inputs();
        bus.i_Repeat = RW'($urandom);
    endtask

    // Check len*(reps+1) contiguous valid words, then the done pulse.
    task automatic expect_stream(input int reps, input bit noise);
        int len;
        int n;
        len = model_q.size();
        n   = len * (reps + 1);
        for (int k = 0; k < n; k++) begin
            if (noise) begin
                bus.i_Wr_En   = 1'($urandom);
                bus.i_Wr_Data = BD'($urandom);
                bus.i_Clear   = 1'($urandom);
                bus.i_Start   = 1'($urandom);
                bus.i_Repeat  = RW'($urandom);
            end
            tick();
            chk($sformatf("valid[%0d]", k), int'(bus.o_Valid_WB_Param), 1);
            chk($sformatf("data[%0d]", k), int'(bus.o_Param_WB), model_q[k % len]);
            if (k == 0 && n > 1) begin
                chk("busy_stream", int'(bus.o_Busy), 1);
                chk("wr_ready_stream", int'(bus.o_Wr_Ready), 0);
            end
        end
        idle_inputs();
        tick();
        chk("valid_done", int'(bus.o_Valid_WB_Param), 0);
        chk("data_done", int'(bus.o_Param_WB), 0);
        chk("done_pulse", int'(bus.o_Done), 1);
        chk("busy_done", int'(bus.o_Busy), 0);
        tick();
        chk("done_low", int'(bus.o_Done), 0);
        chk("valid_idle", int'(bus.o_Valid_WB_Param), 0);
        chk("count_kept", int'(bus.o_Count), model_q.size());
    endtask

    initial begin
        int reps;
        int n;
        idle_inputs();
        bus.i_Repeat = '0;
        RST = 1'b1;
        #12;
        // Reset state.
        chk("rst_valid", int'(bus.o_Valid_WB_Param), 0);
        chk("rst_data", int'(bus.o_Param_WB), 0);
        chk("rst_done", int'(bus.o_Done), 0);
        chk("rst_busy", int'(bus.o_Busy), 0);
        chk("rst_count", int'(bus.o_Count), 0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Basic 3-word stream, then replay with random repeat.
        wr(3, 0); wr(5, 0); wr(7, 0);
        start(0, 0, 0, 0);
        expect_stream(0, 0);
        chk("count_3", int'(bus.o_Count), 3);
        reps = $urandom_range(1, 3);
        start(reps, 0, 0, 0);
        expect_stream(reps, 0);

        // Start with empty buffer: ignored.
        clear();
        start(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("empty_valid", int'(bus.o_Valid_WB_Param), 0);
            chk("empty_done", int'(bus.o_Done), 0);
            chk("empty_busy", int'(bus.o_Busy), 0);
            tick();
        end
        // Write together with start is part of the stream.
        start(0, 1, 'hAA, 0);
        expect_stream(0, 0);

        // Clear with write: clear wins.
        wr('h55, 1);
        chk("clr_wins", int'(bus.o_Count), 0);

        // Fill to capacity, overflow write dropped, 3 passes with noisy inputs.
        for (int i = 0; i < 16; i++) wr('h10 + i, 0);
        wr('h20, 0);
        chk("full_count", int'(bus.o_Count), 16);
        start(2, 0, 0, 0);
        expect_stream(2, 1);

        // Randomized rounds; start may coincide with write and clear.
        for (int r = 0; r < 4; r++) begin
            clear();
            n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) wr(int'($urandom_range(0, 255)), 0);
            reps = $urandom_range(0, 3);
            start(reps, 1'($urandom), int'($urandom_range(0, 255)), 1'($urandom));
            expect_stream(reps, 1'($urandom));
        end

        // Reset during the 2nd valid of a 4-word stream.
        clear();
        for (int i = 0; i < 4; i++) wr(int'($urandom_range(0, 255)), 0);
        start(0, 0, 0, 0);
        tick();
        tick();
        chk("pre_rst_valid", int'(bus.o_Valid_WB_Param), 1);
        chk("pre_rst_data", int'(bus.o_Param_WB), model_q[1]);
        #1 RST = 1'b1;
        #1;
        chk("async_rst_valid", int'(bus.o_Valid_WB_Param), 0);
        chk("async_rst_data", int'(bus.o_Param_WB), 0);
        chk("async_rst_busy", int'(bus.o_Busy), 0);
        @(negedge CLK);
        RST = 1'b0;
        model_q.delete();
        tick();
        chk("post_rst_count", int'(bus.o_Count), 0);
        chk("post_rst_busy", int'(bus.o_Busy), 0);
        chk("post_rst_valid", int'(bus.o_Valid_WB_Param), 0);

`ifdef PARAM_WB_LOADER_STALL_EN
        // Stall for two cycles after the first word: 1,-,-,2,3.
        wr(1, 0); wr(2, 0); wr(3, 0);
        start(0, 0, 0, 0);
        tick();
        chk("stall_w0_valid", int'(bus.o_Valid_WB_Param), 1);
        chk("stall_w0_data", int'(bus.o_Param_WB), 1);
        bus.i_Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_gap_valid", int'(bus.o_Valid_WB_Param), 0);
            chk("stall_gap_data", int'(bus.o_Param_WB), 0);
        end
        bus.i_Stall = 1'b0;
        tick();
        chk("stall_w1_data", int'(bus.o_Param_WB), 2);
        tick();
        chk("stall_w2_data", int'(bus.o_Param_WB), 3);
        chk("stall_w2_valid", int'(bus.o_Valid_WB_Param), 1);
        tick();
        chk("stall_done", int'(bus.o_Done), 1);
        chk("stall_done_valid", int'(bus.o_Valid_WB_Param), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
